// File: rtl/regfile_wb_sequencer.sv
// rtl/regfile_wb_sequencer.sv - Y86-64 register file with dual write-back sequencer
//
// Owns the 15-entry architectural register file and puts the two write-back
// results of an instruction (valE->dstE, valM->dstM) onto one physical write
// port. When both results target different registers, valE is written on the
// accepting edge and valM one edge later; wb_ready is low during that second
// cycle so the controller stalls.
//
// Optional feature: define REGFILE_WB_BYPASS_EN to forward in-flight write
// data onto valA/valB (zero-cycle read-after-write). Without it, reads
// return registered contents only.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   wb_valid/wb_ready write-back request handshake
//   dstE/valE         execute result and its destination (RNONE = none)
//   dstM/valM         memory result and its destination (RNONE = none)
//   srcA/srcB         decode read port register IDs
//   valA/valB         combinational read data
//   reg_flat          all registers, register i at [i*DATA_W +: DATA_W]
//   wr_count          number of physical writes performed, wrapping

module regfile_wb_sequencer #(
  parameter int          DATA_W  = 64,
  parameter int          NREGS   = 15,
  parameter logic [3:0]  RNONE   = 4'hF,
  parameter logic [63:0] SP_INIT = 64'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  logic [3:0]              dstE,
  input  logic [DATA_W-1:0]       valE,
  input  logic [3:0]              dstM,
  input  logic [DATA_W-1:0]       valM,
  input  logic [3:0]              srcA,
  input  logic [3:0]              srcB,
  output logic [DATA_W-1:0]       valA,
  output logic [DATA_W-1:0]       valB,
  output logic [NREGS*DATA_W-1:0] reg_flat,
  output logic [31:0]             wr_count
);

  localparam logic [4:0] NREGS_ID = 5'(NREGS);
  localparam int         SP_ID    = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    PEND_M = 1'b1
  } state_t;

  state_t              state;
  state_t              next_state;

  logic [DATA_W-1:0]   regs [NREGS];

  // Deferred valM write captured when both results target distinct registers.
  logic [3:0]          pend_dst;
  logic [DATA_W-1:0]   pend_val;
  logic                pend_load;

  // Single physical write port, selected combinationally.
  logic                wr_en;
  logic [3:0]          wr_dst;
  logic [DATA_W-1:0]   wr_val;
  logic                wr_ok;

  logic                e_on;
  logic                m_on;

  assign e_on = (dstE != RNONE);
  assign m_on = (dstM != RNONE);

  // Writes to RNONE or to IDs beyond the file are dropped without counting.
  assign wr_ok = wr_en && (wr_dst != RNONE) && ({1'b0, wr_dst} < NREGS_ID);

  assign wb_ready = (state == IDLE);

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    wr_dst     = RNONE;
    wr_val     = '0;
    pend_load  = 1'b0;
    case (state)
      IDLE: begin
        if (wb_valid) begin
          if (e_on && m_on && (dstE != dstM)) begin
            wr_en      = 1'b1;
            wr_dst     = dstE;
            wr_val     = valE;
            pend_load  = 1'b1;
            next_state = PEND_M;
          end else if (m_on) begin
            // Covers M-only and dstE==dstM, where M wins (e.g. popq %rsp).
            wr_en  = 1'b1;
            wr_dst = dstM;
            wr_val = valM;
          end else if (e_on) begin
            wr_en  = 1'b1;
            wr_dst = dstE;
            wr_val = valE;
          end
        end
      end
      PEND_M: begin
        // wb_valid is deliberately ignored here; the requester holds it.
        wr_en      = 1'b1;
        wr_dst     = pend_dst;
        wr_val     = pend_val;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pend_dst <= RNONE;
      pend_val <= '0;
      wr_count <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_ID) ? SP_INIT[DATA_W-1:0] : '0;
      end
    end else begin
      state <= next_state;
      if (pend_load) begin
        pend_dst <= dstM;
        pend_val <= valM;
      end
      if (wr_ok) begin
        regs[wr_dst] <= wr_val;
        wr_count     <= wr_count + 32'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_flat
      assign reg_flat[gi*DATA_W +: DATA_W] = regs[gi];
    end
  endgenerate

  // Both read ports share one lookup loop.
  logic [3:0]        rd_src [2];
  logic [DATA_W-1:0] rd_val [2];

  assign rd_src[0] = srcA;
  assign rd_src[1] = srcB;
  assign valA      = rd_val[0];
  assign valB      = rd_val[1];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = '0;
      if ((rd_src[p] != RNONE) && ({1'b0, rd_src[p]} < NREGS_ID)) begin
`ifdef REGFILE_WB_BYPASS_EN
        // Newest data first: pending M, then this cycle's accepted write
        // (M before E), then the register itself. Nothing is forwarded
        // while reset is asserted since no write can happen then.
        if (!reset && (state == PEND_M) && (pend_dst == rd_src[p])) begin
          rd_val[p] = pend_val;
        end else if (!reset && (state == IDLE) && wb_valid && m_on &&
                     (dstM == rd_src[p])) begin
          rd_val[p] = valM;
        end else if (!reset && (state == IDLE) && wb_valid && e_on &&
                     (dstE == rd_src[p])) begin
          rd_val[p] = valE;
        end else begin
          rd_val[p] = regs[rd_src[p]];
        end
`else
        rd_val[p] = regs[rd_src[p]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// tb/tb_regfile_wb_sequencer.sv - randomized self-checking bench for regfile_wb_sequencer

module tb_regfile_wb_sequencer;

  localparam logic [63:0] SP_INIT = 64'h100;
  localparam logic [3:0]  RN      = 4'hF;

  logic         clk;
  logic         reset;
  logic         wb_valid;
  logic         wb_ready;
  logic [3:0]   dstE;
  logic [63:0]  valE;
  logic [3:0]   dstM;
  logic [63:0]  valM;
  logic [3:0]   srcA;
  logic [3:0]   srcB;
  logic [63:0]  valA;
  logic [63:0]  valB;
  logic [959:0] reg_flat;
  logic [31:0]  wr_count;

  regfile_wb_sequencer #(
    .DATA_W (64),
    .NREGS  (15),
    .RNONE  (4'hF),
    .SP_INIT(SP_INIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .dstE    (dstE),
    .valE    (valE),
    .dstM    (dstM),
    .valM    (valM),
    .srcA    (srcA),
    .srcB    (srcB),
    .valA    (valA),
    .valB    (valB),
    .reg_flat(reg_flat),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers, a write counter and a queue
  // of writes still owed to the register file.
  typedef struct {
    logic [3:0]  dst;
    logic [63:0] val;
  } wr_t;

  logic [63:0] m_regs [15];
  logic [31:0] m_cnt;
  wr_t         m_pend [$];
  logic [63:0] last_valA;

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? SP_INIT : 64'd0;
    m_cnt = 32'd0;
    m_pend.delete();
  endtask

  task automatic model_apply(input wr_t w);
    if (w.dst <= 4'd14) begin
      m_regs[w.dst] = w.val;
      m_cnt         = m_cnt + 32'd1;
    end
  endtask

  task automatic model_edge(input logic r, input logic v,
                            input logic [3:0] de, input logic [63:0] ve,
                            input logic [3:0] dm, input logic [63:0] vm);
    wr_t ws [$];
    wr_t w;
    if (r) begin
      model_reset();
    end else if (m_pend.size() > 0) begin
      w = m_pend.pop_front();
      model_apply(w);
    end else if (v) begin
      if (de != RN && dm != RN && de == dm) begin
        ws.push_back('{dm, vm});
      end else begin
        if (de != RN) ws.push_back('{de, ve});
        if (dm != RN) ws.push_back('{dm, vm});
      end
      if (ws.size() > 0) begin
        w = ws.pop_front();
        model_apply(w);
        while (ws.size() > 0) m_pend.push_back(ws.pop_front());
      end
    end
  endtask

  function automatic logic [63:0] exp_read(input logic [3:0] src, input logic r, input logic v,
                                           input logic [3:0] de, input logic [63:0] ve,
                                           input logic [3:0] dm, input logic [63:0] vm);
    if (src > 4'd14) return 64'd0;
`ifdef REGFILE_WB_BYPASS_EN
    if (!r) begin
      if (m_pend.size() > 0) begin
        if (m_pend[0].dst == src) return m_pend[0].val;
      end else if (v) begin
        if (dm != RN && dm == src) return vm;
        if (de != RN && de == src) return ve;
      end
    end
`endif
    return m_regs[src];
  endfunction

  // One clock: drive at the falling edge, check reads and ready before the
  // rising edge, advance the model, then check the register file after it.
  task automatic run_cycle(input logic r, input logic v,
                           input logic [3:0] de, input logic [63:0] ve,
                           input logic [3:0] dm, input logic [63:0] vm,
                           input logic [3:0] sa, input logic [3:0] sb);
    reset = r; wb_valid = v; dstE = de; valE = ve; dstM = dm; valM = vm;
    srcA = sa; srcB = sb;
    #1;
    check("ready_pre", {63'd0, wb_ready}, {63'd0, m_pend.size() == 0});
    check("valA", valA, exp_read(sa, r, v, de, ve, dm, vm));
    check("valB", valB, exp_read(sb, r, v, de, ve, dm, vm));
    last_valA = valA;
    @(posedge clk);
    model_edge(r, v, de, ve, dm, vm);
    #1;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("r%0d", i), reg_flat[i*64 +: 64], m_regs[i]);
    end
    check("wr_count", {32'd0, wr_count}, {32'd0, m_cnt});
    check("ready_post", {63'd0, wb_ready}, {63'd0, m_pend.size() == 0});
    @(negedge clk);
  endtask

  function automatic logic [3:0] rnd_dst();
    if ($urandom_range(0, 3) == 0) return RN;
    return 4'($urandom_range(0, 14));
  endfunction

  initial begin
    logic [3:0]  de, dm;
    logic [63:0] ve, vm;
    logic        v, r;

    reset = 1'b1; wb_valid = 1'b0; dstE = RN; valE = '0; dstM = RN; valM = '0;
    srcA = RN; srcB = RN; last_valA = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset values.
    run_cycle(1'b1, 1'b0, RN, 64'd0, RN, 64'd0, 4'd4, 4'd0);
    check("rst_r4", reg_flat[4*64 +: 64], 64'h100);
    check("rst_r0", reg_flat[0 +: 64], 64'd0);
    check("rst_ready", {63'd0, wb_ready}, 64'd1);
    check("rst_count", {32'd0, wr_count}, 64'd0);
    run_cycle(1'b0, 1'b0, RN, 64'd0, RN, 64'd0, 4'd4, RN);

    // Single E write.
    run_cycle(1'b0, 1'b1, 4'd2, 64'h55, RN, 64'd0, 4'd2, 4'd3);
    check("e_r2", reg_flat[2*64 +: 64], 64'h55);
    check("e_count", {32'd0, wr_count}, 64'd1);
    check("e_ready", {63'd0, wb_ready}, 64'd1);

    // Dual write: E now, M next edge; request held while stalled.
    run_cycle(1'b0, 1'b1, 4'd4, 64'hF8, 4'd0, 64'hABCD, 4'd0, 4'd4);
    check("dual_r4", reg_flat[4*64 +: 64], 64'hF8);
    check("dual_ready0", {63'd0, wb_ready}, 64'd0);
    run_cycle(1'b0, 1'b1, 4'd4, 64'hF8, 4'd0, 64'hABCD, 4'd0, 4'd4);
    check("dual_r0", reg_flat[0 +: 64], 64'hABCD);
    check("dual_ready1", {63'd0, wb_ready}, 64'd1);
    check("dual_count", {32'd0, wr_count}, 64'd3);

    // Same destination: M wins, single write.
    run_cycle(1'b0, 1'b1, 4'd4, 64'h108, 4'd4, 64'h77, 4'd4, RN);
    check("same_r4", reg_flat[4*64 +: 64], 64'h77);
    check("same_count", {32'd0, wr_count}, 64'd4);
    check("same_ready", {63'd0, wb_ready}, 64'd1);

    // Read of a register with a pending M write.
    run_cycle(1'b0, 1'b1, 4'd6, 64'h66, RN, 64'd0, RN, RN);
    run_cycle(1'b0, 1'b1, 4'd1, 64'h11, 4'd6, 64'h1234, RN, RN);
    run_cycle(1'b0, 1'b0, RN, 64'd0, RN, 64'd0, 4'd6, 4'd1);
`ifdef REGFILE_WB_BYPASS_EN
    check("pend_valA", last_valA, 64'h1234);
`else
    check("pend_valA", last_valA, 64'h66);
`endif
    check("pend_r6", reg_flat[6*64 +: 64], 64'h1234);
    check("pend_count", {32'd0, wr_count}, 64'd7);

    // Reset while PEND_M drops the owed write.
    run_cycle(1'b0, 1'b1, 4'd5, 64'h5, 4'd3, 64'h9, RN, RN);
    run_cycle(1'b1, 1'b1, 4'd5, 64'h5, 4'd3, 64'h9, 4'd3, RN);
    check("rstp_r3", reg_flat[3*64 +: 64], 64'd0);
    check("rstp_ready", {63'd0, wb_ready}, 64'd1);
    check("rstp_count", {32'd0, wr_count}, 64'd0);

    // Randomized traffic; wb_valid is random junk during stalls.
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 9) < 6);
      de = rnd_dst();
      dm = ($urandom_range(0, 5) == 0) ? de : rnd_dst();
      ve = {$urandom, $urandom};
      vm = {$urandom, $urandom};
      run_cycle(r, v, de, ve, dm, vm, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
